// File: rtl/wb_regfile.sv
// MIPS write-back stage: load alignment/extension, result select, and the
// 32x32 general register file with write-first bypass and a committed-write counter.
module wb_regfile #(
    parameter int NREG = 32,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     PCPlus8W,
    input  logic [31:0]     ALUOutW,
    input  logic [31:0]     ReadDataW,
    input  logic [4:0]      WriteRegW,
    input  logic            RegWriteW,
    input  logic            MemToRegW,
    input  logic            IsJJalW,
    input  logic            IsJrJalrW,
    input  logic            IsUnsignedW,
    input  logic [3:0]      BEOutW,
    input  logic [4:0]      RA1D,
    input  logic [4:0]      RA2D,
    output logic [31:0]     RD1D,
    output logic [31:0]     RD2D,
    output logic [31:0]     ResultW,
    output logic [CNTW-1:0] WbCountW
);

    logic [31:0] regs [NREG];
    logic [31:0] load_data;
    logic        we;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic uns);
        return uns ? {24'b0, b} : {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic uns);
        return uns ? {16'b0, h} : {{16{h[15]}}, h};
    endfunction

    // Patterns that are not a legal byte/half lane pass the word through untouched.
    always_comb begin
        load_data = ReadDataW;
        case (BEOutW)
            4'b0011: load_data = ext16(ReadDataW[15:0],  IsUnsignedW);
            4'b1100: load_data = ext16(ReadDataW[31:16], IsUnsignedW);
            4'b0001: load_data = ext8(ReadDataW[7:0],    IsUnsignedW);
            4'b0010: load_data = ext8(ReadDataW[15:8],   IsUnsignedW);
            4'b0100: load_data = ext8(ReadDataW[23:16],  IsUnsignedW);
            4'b1000: load_data = ext8(ReadDataW[31:24],  IsUnsignedW);
            default: load_data = ReadDataW;
        endcase
    end

    always_comb begin
        ResultW = ALUOutW;
        if (IsJJalW || IsJrJalrW) begin
            ResultW = PCPlus8W;
        end else if (MemToRegW) begin
            ResultW = load_data;
        end
    end

    // Reset suppresses the commit, which also disables the read bypass below.
    assign we = RegWriteW && (WriteRegW != 5'd0) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            WbCountW <= '0;
        end else if (we) begin
            regs[WriteRegW] <= ResultW;
            WbCountW        <= WbCountW + {{(CNTW-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        RD1D = regs[RA1D];
        if (RA1D == 5'd0) begin
            RD1D = '0;
        end else if (we && (RA1D == WriteRegW)) begin
            RD1D = ResultW;
        end
    end

    always_comb begin
        RD2D = regs[RA2D];
        if (RA2D == 5'd0) begin
            RD2D = '0;
        end else if (we && (RA2D == WriteRegW)) begin
            RD2D = ResultW;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: a table of write-back vectors, hand-written reset/r0/dual-read
// sequences, random traffic against a shadow register model, and a 4-bit counter wrap.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCPlus8W, ALUOutW, ReadDataW;
    logic [4:0]  WriteRegW, RA1D, RA2D;
    logic        RegWriteW, MemToRegW, IsJJalW, IsJrJalrW, IsUnsignedW;
    logic [3:0]  BEOutW;
    logic [31:0] RD1D, RD2D, ResultW, WbCountW;
    logic [31:0] RD1D4, RD2D4, ResultW4;
    logic [3:0]  WbCountW4;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] shadow [32];
    logic [31:0] cnt_model;

    typedef struct {
        logic [3:0]  be;
        logic        uns;
        logic        mem;
        logic        jj;
        logic        jr;
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [4:0]  wreg;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[16];

    wb_regfile dut (
        .clk(clk), .rst(rst), .PCPlus8W(PCPlus8W), .ALUOutW(ALUOutW), .ReadDataW(ReadDataW),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW), .IsJJalW(IsJJalW),
        .IsJrJalrW(IsJrJalrW), .IsUnsignedW(IsUnsignedW), .BEOutW(BEOutW), .RA1D(RA1D),
        .RA2D(RA2D), .RD1D(RD1D), .RD2D(RD2D), .ResultW(ResultW), .WbCountW(WbCountW)
    );

    wb_regfile #(.CNTW(4)) dut4 (
        .clk(clk), .rst(rst), .PCPlus8W(PCPlus8W), .ALUOutW(ALUOutW), .ReadDataW(ReadDataW),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW), .IsJJalW(IsJJalW),
        .IsJrJalrW(IsJrJalrW), .IsUnsignedW(IsUnsignedW), .BEOutW(BEOutW), .RA1D(RA1D),
        .RA2D(RA2D), .RD1D(RD1D4), .RD2D(RD2D4), .ResultW(ResultW4), .WbCountW(WbCountW4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, want %08h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name, input logic [31:0] act);
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: got %08h, want <scoreboard empty>", name, act);
        end else begin
            exp = exp_q.pop_front();
            chk(name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        PCPlus8W = '0; ALUOutW = '0; ReadDataW = '0; WriteRegW = '0;
        RegWriteW = 1'b0; MemToRegW = 1'b0; IsJJalW = 1'b0; IsJrJalrW = 1'b0;
        IsUnsignedW = 1'b0; BEOutW = '0; RA1D = '0; RA2D = '0;
    endtask

    task automatic reset_pulse();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        cnt_model = '0;
    endtask

    task automatic alu_write(input logic [4:0] r, input logic [31:0] v);
        idle();
        RegWriteW = 1'b1; WriteRegW = r; ALUOutW = v;
        step();
        if (r != 0) begin
            shadow[r] = v;
            cnt_model = cnt_model + 1;
        end
    endtask

    function automatic logic [31:0] port_model(input logic [4:0] ra);
        if (ra == 0) return '0;
        if (RegWriteW && WriteRegW != 0 && !rst && ra == WriteRegW) return ALUOutW;
        return shadow[ra];
    endfunction

    initial begin
        vecs[0]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h12345678, 32'h0,        5'd5,  32'h12345678};
        vecs[1]  = '{4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80F07F81,  32'h0,        32'h0,        5'd8,  32'hFFFFFF81};
        vecs[2]  = '{4'b0001, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80F07F81,  32'h0,        32'h0,        5'd8,  32'h00000081};
        vecs[3]  = '{4'b1100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80F07F81,  32'h0,        32'h0,        5'd8,  32'hFFFF80F0};
        vecs[4]  = '{4'b0010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80F07F81,  32'h0,        32'h0,        5'd8,  32'h0000007F};
        vecs[5]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80F07F81,  32'h0,        32'h0,        5'd9,  32'hFFFFFFF0};
        vecs[6]  = '{4'b1000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80F07F81,  32'h0,        32'h0,        5'd10, 32'h00000080};
        vecs[7]  = '{4'b1000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80F07F81,  32'h0,        32'h0,        5'd10, 32'hFFFFFF80};
        vecs[8]  = '{4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80F07F81,  32'h0,        32'h0,        5'd11, 32'h00007F81};
        vecs[9]  = '{4'b0011, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000F001,  32'h0,        32'h0,        5'd11, 32'hFFFFF001};
        vecs[10] = '{4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80F07F81,  32'h0,        32'h0,        5'd12, 32'h80F07F81};
        vecs[11] = '{4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80F07F81,  32'h0,        32'h0,        5'd13, 32'h80F07F81};
        vecs[12] = '{4'b0101, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80F07F81,  32'h0,        32'h0,        5'd13, 32'h80F07F81};
        vecs[13] = '{4'b1100, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80F07F81,  32'h0,        32'h0,        5'd14, 32'h000080F0};
        vecs[14] = '{4'b0001, 1'b0, 1'b1, 1'b1, 1'b0, 32'h80F07F81,  32'h0,        32'h00400010, 5'd31, 32'h00400010};
        vecs[15] = '{4'b0001, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80F07F81,  32'hCAFEF00D, 32'h00400010, 5'd31, 32'h00400010};

        // Power-on reset and reset-state checks.
        idle();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        cnt_model = '0;
        RA1D = 5'($urandom_range(1, 31));
        RA2D = 5'($urandom_range(1, 31));
        #1;
        chk("reset_rd1", RD1D, 32'h0);
        chk("reset_rd2", RD2D, 32'h0);
        chk("reset_cnt", WbCountW, 32'h0);
        chk("reset_cnt4", {28'h0, WbCountW4}, 32'h0);

        // Table vectors: bypass in the commit cycle, stored value one cycle later.
        for (int i = 0; i < 16; i++) begin
            idle();
            RegWriteW = 1'b1; WriteRegW = vecs[i].wreg; ALUOutW = vecs[i].alu;
            ReadDataW = vecs[i].rdata; PCPlus8W = vecs[i].pc; MemToRegW = vecs[i].mem;
            IsJJalW = vecs[i].jj; IsJrJalrW = vecs[i].jr; IsUnsignedW = vecs[i].uns;
            BEOutW = vecs[i].be; RA1D = vecs[i].wreg;
            exp_q.push_back(vecs[i].exp);
            exp_q.push_back(vecs[i].exp);
            #1;
            sb_check($sformatf("v%0d_result", i), ResultW);
            sb_check($sformatf("v%0d_bypass", i), RD1D);
            step();
            shadow[vecs[i].wreg] = vecs[i].exp;
            cnt_model = cnt_model + 1;
            idle();
            RA2D = vecs[i].wreg;
            exp_q.push_back(vecs[i].exp);
            #1;
            sb_check($sformatf("v%0d_stored", i), RD2D);
            chk($sformatf("v%0d_count", i), WbCountW, cnt_model);
        end

        // Register 0 is never written and never bypassed.
        idle();
        RegWriteW = 1'b1; WriteRegW = 5'd0; ALUOutW = 32'hDEADBEEF;
        #1;
        chk("r0_result", ResultW, 32'hDEADBEEF);
        chk("r0_same", RD1D, 32'h0);
        step();
        idle();
        #1;
        chk("r0_next", RD1D, 32'h0);
        chk("r0_count", WbCountW, cnt_model);

        // Reset beats a coincident write; no bypass while rst is high.
        reset_pulse();
        idle();
        rst = 1'b1; RegWriteW = 1'b1; WriteRegW = 5'd3; ALUOutW = 32'd7; RA2D = 5'd3;
        #1;
        chk("rstwr_during", RD2D, 32'h0);
        step();
        rst = 1'b0;
        idle();
        RA2D = 5'd3; RA1D = 5'd5;
        #1;
        chk("rstwr_rd2", RD2D, 32'h0);
        chk("rstwr_r5", RD1D, 32'h0);
        chk("rstwr_cnt", WbCountW, 32'h0);

        // Mid-stream reset clears everything in one cycle.
        alu_write(5'd4, 32'hA5A5A5A5);
        reset_pulse();
        RA1D = 5'd4;
        #1;
        chk("midrst_r4", RD1D, 32'h0);

        // Dual read of the same register while it is being written.
        alu_write(5'd1, 32'd1);
        alu_write(5'd2, 32'd2);
        idle();
        RegWriteW = 1'b1; WriteRegW = 5'd2; ALUOutW = 32'd9; RA1D = 5'd2; RA2D = 5'd2;
        #1;
        chk("dual_rd1", RD1D, 32'd9);
        chk("dual_rd2", RD2D, 32'd9);
        step();
        shadow[2] = 32'd9;
        cnt_model = cnt_model + 1;
        idle();
        RA1D = 5'd1; RA2D = 5'd2;
        #1;
        chk("dual_r1", RD1D, 32'd1);
        chk("dual_r2", RD2D, 32'd9);

        // Random traffic against the shadow model.
        for (int i = 0; i < 60; i++) begin
            idle();
            RegWriteW = 1'($urandom_range(0, 1));
            WriteRegW = 5'($urandom_range(0, 31));
            ALUOutW = $urandom;
            RA1D = 5'($urandom_range(0, 31));
            RA2D = ($urandom_range(0, 3) == 0) ? WriteRegW : 5'($urandom_range(0, 31));
            exp_q.push_back(port_model(RA1D));
            exp_q.push_back(port_model(RA2D));
            #1;
            sb_check($sformatf("rnd%0d_rd1", i), RD1D);
            sb_check($sformatf("rnd%0d_rd2", i), RD2D);
            step();
            if (RegWriteW && WriteRegW != 0) begin
                shadow[WriteRegW] = ALUOutW;
                cnt_model = cnt_model + 1;
            end
        end
        idle();
        #1;
        chk("rnd_count", WbCountW, cnt_model);

        // Counter wrap on the 4-bit instance.
        reset_pulse();
        for (int i = 0; i < 15; i++) alu_write(5'(i % 31 + 1), 32'(i));
        #1;
        chk("wrap_cnt4_15", {28'h0, WbCountW4}, 32'd15);
        alu_write(5'd20, 32'h0);
        #1;
        chk("wrap_cnt4_0", {28'h0, WbCountW4}, 32'd0);
        chk("wrap_cnt32", WbCountW, 32'd16);

        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_leftover: got %0d entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
